// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of core request/grant, host loader and shared
//                memory command signals around the memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
);
    logic [N_CORES-1:0]        core_req;
    logic [N_CORES-1:0]        core_wr_en;
    logic [N_CORES*ADDR_W-1:0] core_addr;
    logic [N_CORES*DATA_W-1:0] core_wdata;
    logic [N_CORES-1:0]        core_gnt;
    logic [N_CORES-1:0]        core_rvalid;
    logic [DATA_W-1:0]         core_rdata;
    logic                      host_en;
    logic                      host_wr_en;
    logic [ADDR_W-1:0]         host_addr;
    logic [DATA_W-1:0]         host_wdata;
    logic                      host_own;
    logic                      mem_wr_en;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;

    // Arbiter side
    modport slave (
        input  core_req, core_wr_en, core_addr, core_wdata,
        input  host_en, host_wr_en, host_addr, host_wdata,
        input  mem_rdata,
        output core_gnt, core_rvalid, core_rdata, host_own,
        output mem_wr_en, mem_addr, mem_wdata
    );

    // Cores, host loader and memory side
    modport master (
        output core_req, core_wr_en, core_addr, core_wdata,
        output host_en, host_wr_en, host_addr, host_wdata,
        output mem_rdata,
        input  core_gnt, core_rvalid, core_rdata, host_own,
        input  mem_wr_en, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Round-robin arbiter giving N cores one-transaction-per-two-
//                cycles access to a shared memory port, with a host loader
//                that can take the port over after in-flight reads drain.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    mem_arbiter_if.slave bus
);
    localparam int c_PTR_W = $clog2(N_CORES);
    localparam logic [c_PTR_W:0]   c_N_EXT = (c_PTR_W+1)'(N_CORES);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(N_CORES - 1);
    localparam logic [N_CORES-1:0] c_ONE   = N_CORES'(1);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOST  = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_PTR_W-1:0]  r_ptr;
    logic [N_CORES-1:0]  r_gnt;
    logic [N_CORES-1:0]  r_rvalid;
    logic                r_host_own;
    logic                r_mem_wr_en;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic                w_found;
    logic [c_PTR_W-1:0]  w_winner;
    logic [c_PTR_W:0]    w_idx;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_gnt_busy;
    logic                w_read_inflight;

    // A grant is on the bus this cycle; a read grant owes an rvalid next cycle.
    assign w_gnt_busy      = |r_gnt;
    assign w_read_inflight = w_gnt_busy & ~r_mem_wr_en;

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_idx    = '0;
        for (int i = 0; i < N_CORES; i++) begin
            w_idx = {1'b0, r_ptr} + (c_PTR_W+1)'(i);
            if (w_idx >= c_N_EXT) begin
                w_idx = w_idx - c_N_EXT;
            end
            if (!w_found && bus.core_req[w_idx[c_PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[c_PTR_W-1:0];
            end
        end
    end

    assign w_sel_addr  = bus.core_addr[w_winner*ADDR_W +: ADDR_W];
    assign w_sel_wdata = bus.core_wdata[w_winner*DATA_W +: DATA_W];

    // Ownership FSM with registered grant, rvalid and memory command outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ARB;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_host_own  <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            // Grants and write strobes are single-cycle pulses by default.
            r_gnt       <= '0;
            r_mem_wr_en <= 1'b0;
            r_rvalid    <= w_read_inflight ? r_gnt : '0;
            case (r_state)
                ST_ARB: begin
                    if (bus.host_en) begin
                        // Host wins over any same-cycle request, which stays pending.
                        if (w_read_inflight) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_state    <= ST_HOST;
                            r_host_own <= 1'b1;
                        end
                    end else if (!w_gnt_busy && w_found) begin
                        r_gnt       <= c_ONE << w_winner;
                        r_mem_wr_en <= bus.core_wr_en[w_winner];
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_ptr       <= (w_winner == c_LAST) ? '0 : w_winner + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // The outstanding rvalid is delivered during this cycle.
                    r_state    <= ST_HOST;
                    r_host_own <= 1'b1;
                end
                ST_HOST: begin
                    if (!bus.host_en) begin
                        r_state    <= ST_ARB;
                        r_host_own <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_ARB;
                    r_host_own <= 1'b0;
                end
            endcase
        end
    end

    assign bus.core_gnt    = r_gnt;
    assign bus.core_rvalid = r_rvalid;
    assign bus.core_rdata  = (|r_rvalid) ? bus.mem_rdata : '0;
    assign bus.host_own    = r_host_own;
    assign bus.mem_wr_en   = r_host_own ? bus.host_wr_en : r_mem_wr_en;
    assign bus.mem_addr    = r_host_own ? bus.host_addr  : r_mem_addr;
    assign bus.mem_wdata   = r_host_own ? bus.host_wdata : r_mem_wdata;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter N_CORES, default 4, giving the number of core requesters (2..8).
REQ-002 The block SHALL have parameter ADDR_W, default 16, giving the shared data-memory address width.
REQ-003 The block SHALL have parameter DATA_W, default 16, giving the data width.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 core_req  in  N_CORES  per-core access request; held high until that core's grant is seen.
REQ-007 core_wr_en  in  N_CORES  per-core write(1)/read(0) qualifier.
REQ-008 core_addr  in  N_CORES*ADDR_W  per-core address; core i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 core_wdata  in  N_CORES*DATA_W  per-core write data; packed the same way.
REQ-010 core_gnt  out  N_CORES  one-hot grant, high for exactly one cycle per transaction.
REQ-011 core_rvalid  out  N_CORES  one-hot read-data-valid.
REQ-012 core_rdata  out  DATA_W  read data shared by all cores, qualified by core_rvalid.
REQ-013 host_en  in  1  host loader owns the memory while high.
REQ-014 host_wr_en, host_addr, host_wdata  in  1/ADDR_W/DATA_W  host access, passed through while host owns the memory.
REQ-015 host_own  out  1  high while the memory port is handed to the host.
REQ-016 mem_wr_en, mem_addr, mem_wdata  out  1/ADDR_W/DATA_W  shared memory command port.
REQ-017 mem_rdata  in  DATA_W  memory read data, valid one cycle after the read address.

Function
REQ-018 The FSM SHALL have states ARB, DRAIN and HOST; the reset state is ARB.
REQ-019 In ARB, the block SHALL sample core_req at cycle t, select one winner round-robin starting from the index after the last winner, and in cycle t+1 assert core_gnt[winner] and drive mem_* from that core's inputs.
REQ-020 After every grant, the round-robin pointer SHALL advance to winner+1, wrapping from N_CORES-1 to 0.
REQ-021 The block SHALL issue no grant in the cycle a grant is asserted (one transaction per two cycles): a core still requesting in the grant cycle is treated as a new request.
REQ-022 For a granted read issued in cycle t+1, core_rvalid[winner] SHALL be high and core_rdata SHALL equal mem_rdata in cycle t+2.
REQ-023 When no transaction is issued, mem_wr_en SHALL be 0 and mem_addr/mem_wdata SHALL hold their previous values.
REQ-024 A granted write SHALL drive mem_wr_en=1 for exactly the grant cycle; writes produce no core_rvalid.
REQ-025 When host_en rises in ARB, the block SHALL issue no new grant; it SHALL go to DRAIN if a read is in flight, otherwise to HOST on the next edge.
REQ-026 DRAIN SHALL last until the in-flight core_rvalid is delivered, then go to HOST.
REQ-027 In HOST, host_own SHALL be 1, mem_* SHALL follow host_* combinationally, and core_gnt SHALL stay 0.
REQ-028 When host_en falls in HOST, the block SHALL return to ARB with host_own=0 on the next edge and the round-robin pointer preserved.
REQ-029 A request and a host_en rise in the same cycle SHALL be resolved in favour of the host; the request stays pending.
REQ-030 With a single active requester, the block SHALL grant it every second cycle.
REQ-031 A core dropping core_req before its grant SHALL NOT be granted; the grant is decided from the sampled vector only.

Reset
REQ-032 While rst_n=0, the block SHALL force state=ARB, pointer=0, core_gnt=0, core_rvalid=0, core_rdata=0, host_own=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
REQ-033 Reset asserted mid-transaction SHALL abort it: no pending rvalid or grant appears after rst_n rises.
REQ-034 The first arbitration after reset SHALL start at core 0.

Verification
REQ-035 All four cores request reads from addr 0x10,0x20,0x30,0x40 at cycle 0 -> grants in order 0,1,2,3 on cycles 1,3,5,7; each rvalid one cycle after its grant carries mem[addr].
REQ-036 Core 2 writes 0xBEEF to 0x0005, then core 0 reads 0x0005 -> mem_wr_en pulses once; core 0 rdata=0xBEEF.
REQ-037 host_en rises in the grant cycle of a core-1 read -> core-1 rvalid is delivered in DRAIN, then host_own=1; host writes 0x0000..0x03FF pass through unchanged.
REQ-038 host_en falls while cores 3 and 0 request, with last winner 2 -> core 3 is granted first, then core 0.
REQ-039 rst_n pulled low in the cycle after a read grant -> no rvalid appears; all outputs are 0; the next grant goes to the lowest requesting index at or above 0.
